// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - fetch/decode/execute sequencer for the 9-bit datapath
module seq_ctrl #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      instr,
    output logic [2:0]      alu_cmd,
    input  logic            alu_flag,
    output logic [2:0]      rf_ra,
    output logic [2:0]      rf_rb,
    output logic            rf_we,
    output logic [2:0]      rf_wa,
    output logic            rf_wsel,
    output logic [5:0]      lut_idx,
    input  logic [PC_W-1:0] lut_tgt,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            done,
    output logic            flag_q
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [2:0] OP_LSL = 3'b001;
    localparam logic [2:0] OP_BR  = 3'b010;
    localparam logic [2:0] OP_MEM = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc;
    logic            flag_d;
    logic [2:0]      mem_r_q, mem_r_d;
    logic            mem_st_q, mem_st_d;

    logic [2:0] op, fld_r, fld_s;

    assign op        = instr[8:6];
    assign fld_r     = instr[5:3];
    assign fld_s     = instr[2:0];
    assign pc_inc    = pc_q + PC_W'(1);
    assign imem_addr = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            flag_q   <= 1'b0;
            mem_r_q  <= 3'd0;
            mem_st_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flag_q   <= flag_d;
            mem_r_q  <= mem_r_d;
            mem_st_q <= mem_st_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flag_d   = flag_q;
        mem_r_d  = mem_r_q;
        mem_st_d = mem_st_q;
        alu_cmd  = 3'd0;
        rf_ra    = 3'd0;
        rf_rb    = 3'd0;
        rf_we    = 1'b0;
        rf_wa    = 3'd0;
        rf_wsel  = 1'b0;
        lut_idx  = 6'd0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                done = (state_q == S_HALT);
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    flag_d  = 1'b0;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_BR: begin
                        lut_idx = instr[5:0];
                        pc_d    = flag_q ? lut_tgt : pc_inc;
                        state_d = S_FETCH;
                    end
                    OP_MEM: begin
                        case (instr[2:1])
                            2'b00, 2'b01: begin
                                // Operand register is captured so MEM does not depend on ROM output
                                rf_ra    = fld_r;
                                mem_r_d  = fld_r;
                                mem_st_d = instr[1];
                                state_d  = S_MEM;
                            end
                            2'b11:   state_d = S_HALT;
                            default: begin
                                pc_d    = pc_inc;
                                state_d = S_FETCH;
                            end
                        endcase
                    end
                    default: begin
                        alu_cmd = op;
                        rf_ra   = fld_r;
                        rf_rb   = fld_s;
                        rf_we   = (op != OP_CMP);
                        rf_wa   = fld_r;
                        if (op == OP_SUB || op == OP_CMP || op == OP_LSL) begin
                            flag_d = alu_flag;
                        end
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_st_q;
                rf_ra    = mem_r_q;
                if (dmem_ack) begin
                    rf_we   = !mem_st_q;
                    rf_wa   = mem_r_q;
                    rf_wsel = !mem_st_q;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// tb/tb_seq_ctrl.sv - self-checking bench for seq_ctrl against an instruction-level trace model
module tb_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] imem_addr;
    logic [8:0] instr;
    logic [2:0] alu_cmd, rf_ra, rf_rb, rf_wa;
    logic       alu_flag, rf_we, rf_wsel, dmem_req, dmem_we, dmem_ack, done, flag_q;
    logic [5:0] lut_idx;
    logic [9:0] lut_tgt;

    logic [8:0] rom      [0:1023];
    bit         flag_tab [0:1023];
    int         wait_tab [0:1023];
    logic [9:0] lut      [0:63];
    int         ack_cnt;
    bit         stray_ack = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_ctrl #(.PC_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr), .instr(instr),
        .alu_cmd(alu_cmd), .alu_flag(alu_flag), .rf_ra(rf_ra), .rf_rb(rf_rb),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wsel(rf_wsel), .lut_idx(lut_idx),
        .lut_tgt(lut_tgt), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .done(done), .flag_q(flag_q)
    );

    // Environment: synchronous ROM, combinational LUT, per-address flag and ack latency
    always @(posedge clk) instr <= rom[imem_addr];
    assign lut_tgt  = lut[lut_idx];
    assign alu_flag = flag_tab[imem_addr];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_cnt <= 0;
        else if (dmem_req && !dmem_ack) ack_cnt <= ack_cnt + 1;
        else ack_cnt <= 0;
    end
    assign dmem_ack = dmem_req ? (ack_cnt == wait_tab[imem_addr]) : stray_ack;

    typedef struct {
        logic [9:0] addr;
        bit done, flag, we, wsel, req, dwe;
        logic [2:0] wa, cmd, ra, rb;
        bit chk_alu, chk_ra, chk_rb, chk_lut;
        logic [5:0] lidx;
    } rec_t;

    rec_t exp_q[$];
    logic [9:0] cap [0:15];
    int req_cycles, dwe_cycles, ld_writes;

    function automatic rec_t mk(int pc, bit fl);
        rec_t r;
        r = '{default: 0};
        r.addr = pc[9:0];
        r.flag = fl;
        return r;
    endfunction

    // Interprets the program one instruction at a time and lays out the expected cycle trace
    function automatic void build_trace();
        int pc = 0;
        bit fl = 0;
        logic [8:0] ins;
        logic [2:0] op, r, s;
        rec_t rc;
        exp_q.delete();
        while (exp_q.size() < 300) begin
            ins = rom[pc];
            op = ins[8:6]; r = ins[5:3]; s = ins[2:0];
            exp_q.push_back(mk(pc, fl));
            rc = mk(pc, fl);
            if (op == 3'b010) begin
                rc.chk_lut = 1; rc.lidx = ins[5:0];
                exp_q.push_back(rc);
                pc = fl ? int'(lut[ins[5:0]]) : (pc + 1) % 1024;
            end else if (op == 3'b100) begin
                if (ins[2:1] == 2'b11) begin
                    exp_q.push_back(rc);
                    for (int h = 0; h < 4; h++) begin
                        rc = mk(pc, fl); rc.done = 1; exp_q.push_back(rc);
                    end
                    return;
                end else if (ins[2:1] == 2'b10) begin
                    exp_q.push_back(rc);
                    pc = (pc + 1) % 1024;
                end else begin
                    rc.chk_rb = 1; rc.rb = 0; rc.chk_ra = ins[1]; rc.ra = r;
                    exp_q.push_back(rc);
                    for (int w = 0; w <= wait_tab[pc]; w++) begin
                        rc = mk(pc, fl);
                        rc.req = 1; rc.dwe = ins[1]; rc.chk_rb = 1; rc.rb = 0;
                        rc.chk_ra = ins[1]; rc.ra = r;
                        if (w == wait_tab[pc]) begin
                            rc.we = !ins[1]; rc.wa = r; rc.wsel = 1;
                        end
                        exp_q.push_back(rc);
                    end
                    pc = (pc + 1) % 1024;
                end
            end else begin
                rc.chk_alu = 1; rc.cmd = op; rc.ra = r; rc.rb = s;
                rc.we = (op != 3'b111); rc.wa = r; rc.wsel = 0;
                exp_q.push_back(rc);
                if (op == 3'b001 || op == 3'b110 || op == 3'b111) fl = flag_tab[pc];
                pc = (pc + 1) % 1024;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic check_rec(input rec_t e);
        chk("imem_addr", 32'(imem_addr), 32'(e.addr));
        chk("done", 32'(done), 32'(e.done));
        chk("flag_q", 32'(flag_q), 32'(e.flag));
        chk("rf_we", 32'(rf_we), 32'(e.we));
        chk("dmem_req", 32'(dmem_req), 32'(e.req));
        if (e.req) chk("dmem_we", 32'(dmem_we), 32'(e.dwe));
        if (e.we) begin
            chk("rf_wa", 32'(rf_wa), 32'(e.wa));
            chk("rf_wsel", 32'(rf_wsel), 32'(e.wsel));
        end
        if (e.chk_alu) begin
            chk("alu_cmd", 32'(alu_cmd), 32'(e.cmd));
            chk("rf_ra", 32'(rf_ra), 32'(e.ra));
            chk("rf_rb", 32'(rf_rb), 32'(e.rb));
        end
        if (e.chk_ra) chk("rf_ra_st", 32'(rf_ra), 32'(e.ra));
        if (e.chk_rb) chk("rf_rb_mem", 32'(rf_rb), 32'(e.rb));
        if (e.chk_lut) chk("lut_idx", 32'(lut_idx), 32'(e.lidx));
    endtask

    task automatic clear_tabs();
        for (int i = 0; i < 1024; i++) begin
            rom[i] = 9'b100_000_110; flag_tab[i] = 0; wait_tab[i] = 0;
        end
        for (int i = 0; i < 64; i++) lut[i] = '0;
        stray_ack = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 0; start = 0;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic run_prog(input int stray_a, input int stray_b);
        build_trace();
        req_cycles = 0; dwe_cycles = 0; ld_writes = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge clk);
            start = 0;
            check_rec(exp_q[k]);
            if (k < 16) cap[k] = imem_addr;
            if (dmem_req) req_cycles++;
            if (dmem_req && dmem_we) dwe_cycles++;
            if (rf_we && rf_wsel) ld_writes++;
            if (k == stray_a || k == stray_b) start = 1;
        end
        start = 0;
    endtask

    initial begin
        clear_tabs();
        #2;
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_we", 32'(rf_we), 0);
        do_reset();

        // add r1,r2 then halt; restart from HALT
        rom[0] = 9'b000_001_010;
        rom[1] = 9'b100_000_110;
        run_prog(-1, -1);
        chk("p1_done", 32'(done), 1);
        chk("p1_pc", 32'(imem_addr), 1);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        chk("p1_restart_addr", 32'(imem_addr), 0);
        chk("p1_restart_done", 32'(done), 0);
        @(negedge clk);
        chk("p1_restart_we", 32'(rf_we), 1);

        // cmp/branch taken then not taken, stray start and stray ack ignored
        clear_tabs(); do_reset();
        stray_ack = 1;
        rom[0] = 9'b111_001_010; flag_tab[0] = 1;
        rom[1] = 9'b010_000101;  lut[5] = 10'h2A;
        rom[10'h2A] = 9'b000_001_001; flag_tab[10'h2A] = 1;
        rom[10'h2B] = 9'b111_010_011; flag_tab[10'h2B] = 0;
        rom[10'h2C] = 9'b010_000101;
        rom[10'h2D] = 9'b100_000_110;
        run_prog(1, 2);
        chk("p2_taken_addr", 32'(cap[4]), 32'h2A);
        chk("p2_final_pc", 32'(imem_addr), 32'h2D);
        chk("p2_final_flag", 32'(flag_q), 0);

        // ld with 3 wait cycles, st with immediate ack, flag-neutral ops, nops
        clear_tabs(); do_reset();
        rom[0] = 9'b100_011_000; wait_tab[0] = 3;
        rom[1] = 9'b100_100_010; wait_tab[1] = 0;
        rom[2] = 9'b001_001_010; flag_tab[2] = 1;
        rom[3] = 9'b011_101_110;
        rom[4] = 9'b000_010_011;
        rom[5] = 9'b100_000_100;
        rom[6] = 9'b100_000_101;
        rom[7] = 9'b101_111_000;
        rom[8] = 9'b110_000_001; flag_tab[8] = 0;
        rom[9] = 9'b100_000_110;
        run_prog(-1, -1);
        chk("p3_req_cycles", 32'(req_cycles), 5);
        chk("p3_store_cycles", 32'(dwe_cycles), 1);
        chk("p3_ld_writes", 32'(ld_writes), 1);
        chk("p3_final_pc", 32'(imem_addr), 9);
        chk("p3_final_flag", 32'(flag_q), 0);

        // branch to top of address space, xor there wraps pc to 0
        clear_tabs(); do_reset();
        rom[0] = 9'b010_000011;  lut[3] = 10'd5;
        rom[1] = 9'b110_000_000; flag_tab[1] = 1;
        rom[2] = 9'b010_000001;  lut[1] = 10'd1023;
        rom[1023] = 9'b011_010_011;
        rom[5] = 9'b100_000_110;
        run_prog(-1, -1);
        chk("p4_top_addr", 32'(cap[6]), 1023);
        chk("p4_wrap_addr", 32'(cap[8]), 0);
        chk("p4_final_pc", 32'(imem_addr), 5);
        chk("p4_final_flag", 32'(flag_q), 1);

        // reset while waiting on dmem_ack
        clear_tabs(); do_reset();
        rom[0] = 9'b110_001_001; flag_tab[0] = 1;
        rom[1] = 9'b100_010_010; wait_tab[1] = 20;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        repeat (5) @(negedge clk);
        chk("p5_req_before", 32'(dmem_req), 1);
        chk("p5_flag_before", 32'(flag_q), 1);
        chk("p5_addr_before", 32'(imem_addr), 1);
        #2 rst_n = 0;
        #1;
        chk("p5_req", 32'(dmem_req), 0);
        chk("p5_dwe", 32'(dmem_we), 0);
        chk("p5_addr", 32'(imem_addr), 0);
        chk("p5_flag", 32'(flag_q), 0);
        chk("p5_rf_ra", 32'(rf_ra), 0);
        chk("p5_alu_cmd", 32'(alu_cmd), 0);
        chk("p5_done", 32'(done), 0);
        chk("p5_lut_idx", 32'(lut_idx), 0);
        @(negedge clk); rst_n = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
